// File: rtl/ann_pkg.sv
// Shared constants and FSM encoding for the first-layer sample path.
package ann_pkg;

  localparam int unsigned BROJ_ZNACAJKI   = 60;
  localparam int unsigned SIRINA_ZNACAJKE = 16;
  localparam int unsigned SIRINA_UZORKA   = BROJ_ZNACAJKI * SIRINA_ZNACAJKE;
  localparam int unsigned ZNAK_BIT        = 15;
  localparam int unsigned SIRINA_INDEKSA  = $clog2(BROJ_ZNACAJKI);

  typedef enum logic [0:0] {
    StSakupljanje = 1'b0,
    StPun         = 1'b1
  } stanje_e;

endpackage

// File: rtl/uzorak_izlazni_reg.sv
// Output register for the packed sample: holds data while valid && !ready,
// and allows pop and reload on the same edge so back-to-back frames keep valid high.
module uzorak_izlazni_reg
  import ann_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_ucitaj,
  input  logic [SIRINA_UZORKA-1:0] i_podatak,
  input  logic                     i_ready,
  output logic [SIRINA_UZORKA-1:0] o_podatak,
  output logic                     o_valid,
  output logic                     o_slobodan
);

  logic [SIRINA_UZORKA-1:0] r_podatak;
  logic                     r_valid;

  // Slot is free when empty or being consumed this cycle.
  assign o_slobodan = !r_valid || i_ready;
  assign o_podatak  = r_podatak;
  assign o_valid    = r_valid;

  // Load wins over pop; data only changes on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_podatak <= '0;
      r_valid   <= 1'b0;
    end else if (i_ucitaj) begin
      r_podatak <= i_podatak;
      r_valid   <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/uzorak_sakupljac.sv
// Collects serial sign-magnitude features into a packed sample for the neuron array.
// Optional build macro UZORAK_CLAMP_NEG_EN: store any feature with the sign bit set as zero.
module uzorak_sakupljac
  import ann_pkg::*;
#(
  parameter int unsigned SIRINA_BROJACA_GRESAKA = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SIRINA_ZNACAJKE-1:0]        znacajka,
  input  logic                              znacajka_valid,
  input  logic                              zadnja,
  output logic                              znacajka_ready,
  output logic [SIRINA_UZORKA-1:0]          uzorak,
  output logic                              uzorak_valid,
  input  logic                              uzorak_ready,
  output logic                              greska,
  output logic [SIRINA_BROJACA_GRESAKA-1:0] broj_gresaka
);

  localparam logic [SIRINA_INDEKSA-1:0] ZadnjiIndeks = SIRINA_INDEKSA'(BROJ_ZNACAJKI - 1);
  localparam logic [SIRINA_BROJACA_GRESAKA-1:0] MaxGresaka = '1;

  stanje_e                           r_stanje;
  stanje_e                           w_stanje_sl;
  logic [SIRINA_INDEKSA-1:0]         r_indeks;
  logic [SIRINA_UZORKA-1:0]          r_bafer;
  logic                              r_greska;
  logic [SIRINA_BROJACA_GRESAKA-1:0] r_broj;

  logic                       w_prihvat;
  logic                       w_zadnji_slot;
  logic                       w_greska;
  logic                       w_prenos;
  logic                       w_slot_slobodan;
  logic [SIRINA_ZNACAJKE-1:0] w_podatak;

  assign znacajka_ready = (r_stanje == StSakupljanje);
  assign w_prihvat      = znacajka_valid && znacajka_ready;
  assign w_zadnji_slot  = (r_indeks == ZadnjiIndeks);
  // Framing error: zadnja early, or missing on the final slot.
  assign w_greska       = w_prihvat && (zadnja != w_zadnji_slot);
  assign w_prenos       = (r_stanje == StPun) && w_slot_slobodan;
  assign greska         = r_greska;
  assign broj_gresaka   = r_broj;

`ifdef UZORAK_CLAMP_NEG_EN
  assign w_podatak = znacajka[ZNAK_BIT] ? '0 : znacajka;
`else
  assign w_podatak = znacajka;
`endif

  // Next-state: full after the last slot is written, back to collecting on transfer.
  always_comb begin
    w_stanje_sl = r_stanje;
    case (r_stanje)
      StSakupljanje: if (w_prihvat && w_zadnji_slot) w_stanje_sl = StPun;
      StPun:         if (w_prenos) w_stanje_sl = StSakupljanje;
      default:       w_stanje_sl = StSakupljanje;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stanje <= StSakupljanje;
    else        r_stanje <= w_stanje_sl;
  end

  // Slot index; wraps after the last slot or restarts on an early zadnja.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_indeks <= '0;
    end else if (w_prihvat) begin
      r_indeks <= (w_zadnji_slot || zadnja) ? '0 : r_indeks + 1'b1;
    end
  end

  // Collect buffer write of the accepted feature into its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bafer <= '0;
    end else if (w_prihvat) begin
      r_bafer[r_indeks * SIRINA_ZNACAJKE +: SIRINA_ZNACAJKE] <= w_podatak;
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_greska <= 1'b0;
      r_broj   <= '0;
    end else begin
      r_greska <= w_greska;
      if (w_greska && (r_broj != MaxGresaka)) r_broj <= r_broj + 1'b1;
    end
  end

  uzorak_izlazni_reg u_izlaz (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ucitaj   (w_prenos),
    .i_podatak  (r_bafer),
    .i_ready    (uzorak_ready),
    .o_podatak  (uzorak),
    .o_valid    (uzorak_valid),
    .o_slobodan (w_slot_slobodan)
  );

endmodule

// File: tb/tb_uzorak_sakupljac.sv
// Directed bench for uzorak_sakupljac: frame table plus hand-written corner sequences.
module tb_uzorak_sakupljac;

  logic         clk;
  logic         rst_n;
  logic [15:0]  znacajka;
  logic         znacajka_valid;
  logic         zadnja;
  logic         znacajka_ready;
  logic [959:0] uzorak;
  logic         uzorak_valid;
  logic         uzorak_ready;
  logic         greska;
  logic [7:0]   broj_gresaka;

  int total = 0;
  int bad   = 0;
  int n_greska = 0;

  uzorak_sakupljac dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .znacajka       (znacajka),
    .znacajka_valid (znacajka_valid),
    .zadnja         (zadnja),
    .znacajka_ready (znacajka_ready),
    .uzorak         (uzorak),
    .uzorak_valid   (uzorak_valid),
    .uzorak_ready   (uzorak_ready),
    .greska         (greska),
    .broj_gresaka   (broj_gresaka)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which greska is high.
  always @(negedge clk) if (greska === 1'b1) n_greska <= n_greska + 1;

  typedef struct {
    logic [15:0] baza;   // feature k = baza + k
    int          zk;     // index carrying zadnja; 60 = never
    logic        ov;     // expect uzorak_valid
    int          og;     // expected greska cycles
    int          ob;     // expected broj_gresaka afterwards
  } vek_t;

  vek_t tab [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] slot(input int k);
    return uzorak[k*16 +: 16];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] d, input logic z);
    int n = 0;
    znacajka = d;
    zadnja = z;
    znacajka_valid = 1'b1;
    while (znacajka_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=%b expected ready=1", znacajka_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] baza, input int zk, input int neg_slot);
    int n;
    logic [15:0] d;
    n = (zk < 59) ? zk + 1 : 60;
    for (int k = 0; k < n; k++) begin
      d = baza + 16'(k);
      if (k == neg_slot) d = 16'h8123;
      send(d, k == zk);
    end
    znacajka_valid = 1'b0;
    zadnja = 1'b0;
  endtask

  initial begin
    int start;
    logic [15:0] exp_neg;

    tab[0] = '{16'h0100, 59, 1'b1, 0, 0};
    tab[1] = '{16'h0200, 20, 1'b0, 1, 1};
    tab[2] = '{16'h0300, 59, 1'b1, 0, 1};
    tab[3] = '{16'h0400, 60, 1'b1, 1, 2};
    tab[4] = '{16'h7F00, 59, 1'b1, 0, 2};
    tab[5] = '{16'h0500, 0,  1'b0, 1, 3};

    rst_n = 1'b0;
    znacajka = '0;
    znacajka_valid = 1'b0;
    zadnja = 1'b0;
    uzorak_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(uzorak_valid), 0);
    chk("rst_greska", 32'(greska), 0);
    chk("rst_broj", 32'(broj_gresaka), 0);
    chk("rst_uzorak", 32'(|uzorak), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(znacajka_ready), 1);

    // Frame table.
    for (int i = 0; i < 6; i++) begin
      start = n_greska;
      send_frame(tab[i].baza, tab[i].zk, -1);
      chk($sformatf("t%0d_valid_n", i), 32'(uzorak_valid), 0);
      chk($sformatf("t%0d_ready_n", i), 32'(znacajka_ready), 32'(!tab[i].ov));
      @(negedge clk);
      chk($sformatf("t%0d_valid_n1", i), 32'(uzorak_valid), 32'(tab[i].ov));
      if (tab[i].ov) begin
        chk($sformatf("t%0d_slot0", i), 32'(slot(0)), 32'(tab[i].baza));
        chk($sformatf("t%0d_slot20", i), 32'(slot(20)), 32'(tab[i].baza + 16'd20));
        chk($sformatf("t%0d_slot59", i), 32'(slot(59)), 32'(tab[i].baza + 16'd59));
      end
      @(negedge clk);
      chk($sformatf("t%0d_greska_cyc", i), 32'(n_greska - start), 32'(tab[i].og));
      chk($sformatf("t%0d_broj", i), 32'(broj_gresaka), 32'(tab[i].ob));
    end

    // Backpressure: frame B fills behind a held frame A.
    uzorak_ready = 1'b0;
    send_frame(16'h1000, 59, -1);
    @(negedge clk);
    chk("bp_a_valid", 32'(uzorak_valid), 1);
    chk("bp_a_slot0", 32'(slot(0)), 32'h1000);
    send_frame(16'h2000, 59, -1);
    repeat (3) @(negedge clk);
    chk("bp_ready_low", 32'(znacajka_ready), 0);
    chk("bp_hold_valid", 32'(uzorak_valid), 1);
    chk("bp_hold_slot0", 32'(slot(0)), 32'h1000);
    chk("bp_hold_slot59", 32'(slot(59)), 32'h103B);
    uzorak_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", 32'(uzorak_valid), 1);
    chk("bp_b_slot0", 32'(slot(0)), 32'h2000);
    chk("bp_b_slot59", 32'(slot(59)), 32'h203B);
    chk("bp_ready_back", 32'(znacajka_ready), 1);
    @(negedge clk);
    chk("bp_pop", 32'(uzorak_valid), 0);

    // Saturation: 260 single-feature frames with early zadnja.
    start = n_greska;
    for (int i = 0; i < 260; i++) send(16'h0AAA, 1'b1);
    znacajka_valid = 1'b0;
    zadnja = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sat_pulses", 32'(n_greska - start), 260);
    chk("sat_broj", 32'(broj_gresaka), 255);

    // Reset in the middle of a frame.
    for (int k = 0; k <= 30; k++) send(16'h0E00 + 16'(k), 1'b0);
    znacajka_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_broj", 32'(broj_gresaka), 0);
    chk("mrst_uzorak", 32'(|uzorak), 0);
    chk("mrst_valid", 32'(uzorak_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h3000, 59, -1);
    chk("mrst_full", 32'(znacajka_ready), 0);
    @(negedge clk);
    chk("mrst_valid2", 32'(uzorak_valid), 1);
    chk("mrst_slot0", 32'(slot(0)), 32'h3000);
    chk("mrst_slot59", 32'(slot(59)), 32'h303B);
    chk("mrst_broj2", 32'(broj_gresaka), 0);

    // Reset while an output is held.
    uzorak_ready = 1'b0;
    @(negedge clk);
    send_frame(16'h4000, 59, -1);
    @(negedge clk);
    chk("hrst_valid_pre", 32'(uzorak_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("hrst_valid", 32'(uzorak_valid), 0);
    chk("hrst_uzorak", 32'(|uzorak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    uzorak_ready = 1'b1;
    @(negedge clk);
    chk("hrst_ready", 32'(znacajka_ready), 1);

    // Negative feature in slot 5.
`ifdef UZORAK_CLAMP_NEG_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8123;
`endif
    send_frame(16'h0100, 59, 5);
    @(negedge clk);
    chk("neg_valid", 32'(uzorak_valid), 1);
    chk("neg_slot5", 32'(slot(5)), 32'(exp_neg));
    chk("neg_slot4", 32'(slot(4)), 32'h0104);
    chk("neg_slot6", 32'(slot(6)), 32'h0106);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
